// File: rtl/bus_xbar_rr.sv
// Round-robin crossbar between NUM_MASTERS request ports and NUM_SLAVES target ports.
// Each slave runs its own grant FSM. Each master has at most one transaction in flight.
module bus_xbar_rr #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 2,
    parameter int unsigned SEL_LSB     = 28
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    io_masterFace_in_valid,
    output logic [NUM_MASTERS-1:0]    io_masterFace_in_ready,
    input  logic [3*NUM_MASTERS-1:0]  io_masterFace_in_bits_opcode,
    input  logic [32*NUM_MASTERS-1:0] io_masterFace_in_bits_address,
    input  logic [4*NUM_MASTERS-1:0]  io_masterFace_in_bits_mask,
    input  logic [32*NUM_MASTERS-1:0] io_masterFace_in_bits_data,
    output logic [NUM_MASTERS-1:0]    io_masterFace_out_valid,
    input  logic [NUM_MASTERS-1:0]    io_masterFace_out_ready,
    output logic [32*NUM_MASTERS-1:0] io_masterFace_out_bits_data,
    output logic [NUM_MASTERS-1:0]    io_masterFace_out_bits_error,
    output logic [NUM_SLAVES-1:0]     io_slaveFace_in_valid,
    input  logic [NUM_SLAVES-1:0]     io_slaveFace_in_ready,
    output logic [3*NUM_SLAVES-1:0]   io_slaveFace_in_bits_opcode,
    output logic [32*NUM_SLAVES-1:0]  io_slaveFace_in_bits_address,
    output logic [4*NUM_SLAVES-1:0]   io_slaveFace_in_bits_mask,
    output logic [32*NUM_SLAVES-1:0]  io_slaveFace_in_bits_data,
    input  logic [NUM_SLAVES-1:0]     io_slaveFace_out_valid,
    output logic [NUM_SLAVES-1:0]     io_slaveFace_out_ready,
    input  logic [32*NUM_SLAVES-1:0]  io_slaveFace_out_bits_data
);

    localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]             state    [NUM_SLAVES];
    logic [1:0]             stateNxt [NUM_SLAVES];
    logic [MW-1:0]          own      [NUM_SLAVES];
    logic [MW-1:0]          ownNxt   [NUM_SLAVES];
    logic [MW-1:0]          rr       [NUM_SLAVES];
    logic [MW-1:0]          rrNxt    [NUM_SLAVES];
    logic [3:0]             tgt      [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] badAddr;
    logic [NUM_MASTERS-1:0] busy;
    logic [NUM_MASTERS-1:0] errPend;
    logic [NUM_MASTERS-1:0] aFire;
    logic [NUM_MASTERS-1:0] dFire;
    logic [MW-1:0]          idx;
    logic                   found;
    int unsigned            om;

    // Slave-select decode per master
    always_comb begin
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            tgt[m]     = io_masterFace_in_bits_address[32*m+SEL_LSB +: 4];
            badAddr[m] = (tgt[m] >= 4'(NUM_SLAVES));
        end
    end

    assign aFire = io_masterFace_in_valid & io_masterFace_in_ready;
    assign dFire = io_masterFace_out_valid & io_masterFace_out_ready;

    // Per-slave arbitration FSM, next state
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            stateNxt[s] = state[s];
            ownNxt[s]   = own[s];
            rrNxt[s]    = rr[s];
            found       = 1'b0;
            case (state[s])
                IDLE: begin
                    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
                        idx = MW'((32'(rr[s]) + k) % NUM_MASTERS);
                        if (!found && io_masterFace_in_valid[idx] && !busy[idx] &&
                            !badAddr[idx] && (tgt[idx] == 4'(s))) begin
                            found     = 1'b1;
                            ownNxt[s] = idx;
                        end
                    end
                    if (found) stateNxt[s] = GRANT;
                end
                GRANT: begin
                    if (io_slaveFace_in_ready[s]) begin
                        stateNxt[s] = RESP;
                        rrNxt[s]    = MW'((32'(own[s]) + 32'd1) % NUM_MASTERS);
                    end
                end
                RESP: begin
                    if (io_slaveFace_out_valid[s] && io_masterFace_out_ready[own[s]])
                        stateNxt[s] = IDLE;
                end
                default: stateNxt[s] = IDLE;
            endcase
        end
    end

    // Routing of A and D channels; anything not owned by a grant stays 0
    always_comb begin
        io_masterFace_in_ready       = '0;
        io_masterFace_out_valid      = '0;
        io_masterFace_out_bits_data  = '0;
        io_masterFace_out_bits_error = '0;
        io_slaveFace_in_valid        = '0;
        io_slaveFace_in_bits_opcode  = '0;
        io_slaveFace_in_bits_address = '0;
        io_slaveFace_in_bits_mask    = '0;
        io_slaveFace_in_bits_data    = '0;
        io_slaveFace_out_ready       = '0;
        om                           = '0;
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            if (errPend[m]) begin
                io_masterFace_out_valid[m]      = 1'b1;
                io_masterFace_out_bits_error[m] = 1'b1;
            end else if (io_masterFace_in_valid[m] && !busy[m] && badAddr[m]) begin
                io_masterFace_in_ready[m] = 1'b1;
            end
        end
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            om = 32'(own[s]);
            case (state[s])
                GRANT: begin
                    io_slaveFace_in_valid[s]              = 1'b1;
                    io_slaveFace_in_bits_opcode[3*s +: 3]   = io_masterFace_in_bits_opcode[3*om +: 3];
                    io_slaveFace_in_bits_address[32*s +: 32] = io_masterFace_in_bits_address[32*om +: 32];
                    io_slaveFace_in_bits_mask[4*s +: 4]     = io_masterFace_in_bits_mask[4*om +: 4];
                    io_slaveFace_in_bits_data[32*s +: 32]   = io_masterFace_in_bits_data[32*om +: 32];
                    io_masterFace_in_ready[own[s]]        = io_slaveFace_in_ready[s];
                end
                RESP: begin
                    io_masterFace_out_valid[own[s]] = io_slaveFace_out_valid[s];
                    if (io_slaveFace_out_valid[s])
                        io_masterFace_out_bits_data[32*om +: 32] = io_slaveFace_out_bits_data[32*s +: 32];
                    io_slaveFace_out_ready[s] = io_masterFace_out_ready[own[s]];
                end
                default: ;
            endcase
        end
    end

    // State registers; reset drops any transaction in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
                state[s] <= IDLE;
                own[s]   <= '0;
                rr[s]    <= '0;
            end
            busy    <= '0;
            errPend <= '0;
        end else begin
            for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
                state[s] <= stateNxt[s];
                own[s]   <= ownNxt[s];
                rr[s]    <= rrNxt[s];
            end
            busy    <= (busy & ~dFire) | aFire;
            errPend <= (errPend & ~dFire) | (aFire & badAddr);
        end
    end

endmodule

// File: doc/bus_xbar_rr.md
BUS_XBAR_RR -- requirements
Module: bus_xbar_rr

Parameters
REQ-001 Parameter NUM_MASTERS, default 2: number of master ports, range 1..8.
REQ-002 Parameter NUM_SLAVES, default 2: number of slave ports, range 1..8.
REQ-003 Parameter SEL_LSB, default 28: lowest bit of the slave-select field, address[SEL_LSB+3:SEL_LSB], 4 bits wide.

Interface (one clock; reset is synchronous and active-high)
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 io_masterFace_in_valid  in  NUM_MASTERS  A-channel request valid, one bit per master.
REQ-007 io_masterFace_in_ready  out  NUM_MASTERS  A-channel accept, one bit per master.
REQ-008 io_masterFace_in_bits_opcode/address/mask/data  in  3/32/4/32 x NUM_MASTERS  A payload, master m in slice m.
REQ-009 io_masterFace_out_valid/ready  out/in  NUM_MASTERS  D-channel response handshake.
REQ-010 io_masterFace_out_bits_data/error  out  32/1 x NUM_MASTERS  D payload; error flags a decode fault.
REQ-011 io_slaveFace_in_valid/ready  out/in  NUM_SLAVES  A-channel toward slaves.
REQ-012 io_slaveFace_in_bits_opcode/address/mask/data  out  3/32/4/32 x NUM_SLAVES  forwarded A payload.
REQ-013 io_slaveFace_out_valid/ready  in/out  NUM_SLAVES  D-channel from slaves.
REQ-014 io_slaveFace_out_bits_data  in  32 x NUM_SLAVES  D payload.

Function
REQ-015 Target slave = address[SEL_LSB+3:SEL_LSB]; a value >= NUM_SLAVES is a decode error.
REQ-016 A handshake fires when valid and ready are both high on a rising edge; D likewise; payload is held stable while valid is high and not yet accepted.
REQ-017 Each master has at most one outstanding transaction; busy[m] is set on its A fire and cleared on its D fire.
REQ-018 Each slave runs an FSM IDLE -> GRANT -> RESP -> IDLE, with owner register own[s] and round-robin pointer rr[s].
REQ-019 IDLE: candidates are masters with valid high, busy low and target s; the first candidate at or after rr[s], cyclic, is latched into own[s], and the FSM moves to GRANT next cycle; no candidates means stay in IDLE.
REQ-020 GRANT: io_slaveFace_in_valid[s] is high with own[s]'s payload; master ready[own] = slave ready[s], combinationally; on fire go to RESP and set rr[s] = own[s]+1, modulo NUM_MASTERS.
REQ-021 RESP: slave D data routed to own[s] with error=0; slave out_ready[s] = master out_ready[own]; on fire go to IDLE.
REQ-022 Minimum A latency is 1 cycle (request at cycle 0, slave valid at cycle 1); back-to-back grants to the same slave are 3 cycles apart at best.
REQ-023 Decode error: a non-busy master with a bad address gets ready=1 in that cycle; the next cycle it gets D valid=1, data=0, error=1, held until out_ready; no slave sees the request.
REQ-024 Different slaves operate concurrently; a master never receives two D valids in one cycle, guaranteed by REQ-017.
REQ-025 Slave D valid outside RESP is ignored (out_ready=0 to that slave).
REQ-026 All outputs not driven by an active grant, response or error are 0; payload outputs of idle slaves are 0.

Reset
REQ-027 While reset is high: all FSMs go to IDLE, rr=0, own=0, busy=0, error-pending=0; all valid/ready outputs are 0 in the cycle after reset is sampled.
REQ-028 Reset mid-transaction abandons it silently; no D response is generated afterward.

Verification
REQ-029 M0 writes address 0x1000_0040 with no contention -> slave1 in_valid rises at cycle 1 with identical payload; slave D data 0xCAFE_F00D is returned to M0 with error=0.
REQ-030 M0 and M1 request slave0 simultaneously for 4 rounds, with slaves always ready -> grant order is M0,M1,M0,M1.
REQ-031 M0 targets slave0 while M1 targets slave1 in the same cycle -> both slave in_valid are high at cycle 1, and the responses are independent.
REQ-032 M1 uses address 0xF000_0000 with NUM_SLAVES=2 -> M1 ready=1 at cycle 0, D valid at cycle 1 with data=0, error=1; no slave valid is raised.
REQ-033 Slave0 in_ready is held low 5 cycles in GRANT, then reset is asserted -> all outputs are 0 after reset, and a new request is granted normally.
REQ-034 M0 out_ready is held low 3 cycles in RESP -> slave0 out_ready stays low for the same 3 cycles, the data is held, and M1 is not granted slave0 until D fires.
